// File: rtl/query_dispatcher.sv
// query_dispatcher: fans one parsed query stream out to NUM_ENGINES
// Smith-Waterman engines. A query header is latched, an idle engine is
// chosen by arbitration, and the header plus all of its query blocks are
// steered to that engine.
module query_dispatcher #(
  parameter int unsigned NUM_ENGINES = 4,
  parameter int unsigned NUM_PES     = 64,
  parameter int unsigned ARB_MODE    = 0,
  localparam int unsigned SEL_W      = $clog2(NUM_ENGINES)
) (
  input  logic                     clk,
  input  logic                     rst,
  // upstream query header
  input  logic [24:0]              ref_length_in,
  input  logic [24:0]              ref_addr_in,
  input  logic [15:0]              num_query_blocks_in,
  input  logic [15:0]              query_id_in,
  input  logic [31:0]              cell_score_threshold_in,
  input  logic                     query_info_valid_in,
  output logic                     query_info_rdy_out,
  // upstream query blocks
  input  logic [2*NUM_PES-1:0]     query_seq_block_in,
  input  logic                     query_seq_block_valid_in,
  output logic                     query_seq_block_rdy_out,
  // engine-side header
  output logic [24:0]              eng_ref_length_out,
  output logic [24:0]              eng_ref_addr_out,
  output logic [15:0]              eng_num_query_blocks_out,
  output logic [15:0]              eng_query_id_out,
  output logic [31:0]              eng_cell_score_thr_out,
  output logic [NUM_ENGINES-1:0]   eng_query_info_valid_out,
  input  logic [NUM_ENGINES-1:0]   eng_query_info_rdy_in,
  // engine-side blocks
  output logic [2*NUM_PES-1:0]     eng_query_seq_block_out,
  output logic [NUM_ENGINES-1:0]   eng_query_seq_block_valid_out,
  input  logic [NUM_ENGINES-1:0]   eng_query_seq_block_rdy_in,
  // status
  output logic                     busy_out,
  output logic [SEL_W-1:0]         cur_engine_out
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARB,
    ST_INFO,
    ST_BLOCKS
  } state_t;

  state_t                  state;
  logic [SEL_W-1:0]        sel;
  logic [SEL_W-1:0]        last_grant;
  logic [15:0]             num_blocks;
  logic [15:0]             cnt;

  logic                    arb_found;
  logic [SEL_W-1:0]        arb_pick;
  int unsigned             scan_idx;
  logic [NUM_ENGINES-1:0]  sel_onehot;
  logic                    blk_xfer;

  // Arbitration scan over idle engines: fixed priority (lowest index) or
  // round-robin starting one past the last grant.
  always_comb begin
    arb_found = 1'b0;
    arb_pick  = '0;
    scan_idx  = 0;
    if (ARB_MODE == 1) begin
      for (int unsigned i = 0; i < NUM_ENGINES; i++) begin
        if (!arb_found && eng_query_info_rdy_in[SEL_W'(i)]) begin
          arb_found = 1'b1;
          arb_pick  = SEL_W'(i);
        end
      end
    end else begin
      for (int unsigned i = 1; i <= NUM_ENGINES; i++) begin
        scan_idx = (32'(last_grant) + i) % NUM_ENGINES;
        if (!arb_found && eng_query_info_rdy_in[SEL_W'(scan_idx)]) begin
          arb_found = 1'b1;
          arb_pick  = SEL_W'(scan_idx);
        end
      end
    end
  end

  // Steering decode for the selected engine and block-transfer detect.
  always_comb begin
    sel_onehot = NUM_ENGINES'(1) << sel;
    blk_xfer   = (state == ST_BLOCKS) && query_seq_block_valid_in
                 && eng_query_seq_block_rdy_in[sel];
  end

  // Main dispatcher FSM: header latch, grant, header handoff, block count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                    <= ST_IDLE;
      sel                      <= '0;
      last_grant               <= SEL_W'(NUM_ENGINES - 1);
      num_blocks               <= '0;
      cnt                      <= '0;
      eng_ref_length_out       <= '0;
      eng_ref_addr_out         <= '0;
      eng_num_query_blocks_out <= '0;
      eng_query_id_out         <= '0;
      eng_cell_score_thr_out   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (query_info_valid_in) begin
            eng_ref_length_out       <= ref_length_in;
            eng_ref_addr_out         <= ref_addr_in;
            eng_num_query_blocks_out <= num_query_blocks_in;
            eng_query_id_out         <= query_id_in;
            eng_cell_score_thr_out   <= cell_score_threshold_in;
            num_blocks               <= num_query_blocks_in;
            state                    <= ST_ARB;
          end
        end
        ST_ARB: begin
          if (arb_found) begin
            sel        <= arb_pick;
            last_grant <= arb_pick;
            state      <= ST_INFO;
          end
        end
        ST_INFO: begin
          // Waits on the granted engine only; a dropped ready is not re-arbitrated.
          if (eng_query_info_rdy_in[sel]) begin
            cnt   <= '0;
            state <= (num_blocks == 16'd0) ? ST_IDLE : ST_BLOCKS;
          end
        end
        ST_BLOCKS: begin
          // Compare against num_blocks-1 so cnt never has to reach 65535.
          if (blk_xfer) begin
            if (cnt == num_blocks - 16'd1) begin
              cnt   <= '0;
              state <= ST_IDLE;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Handshake pass-through and status, all gated by the current state.
  always_comb begin
    query_info_rdy_out            = (state == ST_IDLE) && query_info_valid_in;
    eng_query_info_valid_out      = (state == ST_INFO) ? sel_onehot : '0;
    eng_query_seq_block_valid_out = (state == ST_BLOCKS && query_seq_block_valid_in)
                                    ? sel_onehot : '0;
    query_seq_block_rdy_out       = (state == ST_BLOCKS) && eng_query_seq_block_rdy_in[sel];
    eng_query_seq_block_out       = (state == ST_BLOCKS) ? query_seq_block_in : '0;
    busy_out                      = (state != ST_IDLE);
    cur_engine_out                = sel;
  end

endmodule
